// File: rtl/mem_stage_if.sv
// mem_stage_if: EXE->MEM, MEM->WB and data-SRAM response signals of the MEM stage.
// master = surrounding pipeline (EXE/WB/SRAM side), slave = mem_stage.
interface mem_stage_if #(
    parameter int EXCEP_W = 128,
    parameter int TLB_W   = 10
);
    logic               exe_to_mem_valid;
    logic               mem_allowin;
    logic [76:0]        exe_to_mem_bus;
    logic [EXCEP_W-1:0] exe_to_mem_excep;
    logic [TLB_W-1:0]   exe_to_mem_tlb;
    logic               data_sram_data_ok;
    logic [31:0]        data_sram_rdata;
    logic               wb_allowin;
    logic               wb_flush;
    logic               mem_to_wb_valid;
    logic [70:0]        mem_to_wb_signal;
    logic [EXCEP_W-1:0] mem_to_wb_excep;
    logic [TLB_W-1:0]   mem_to_wb_tlb;
    logic [37:0]        mem_rf_zip;
    logic               mem_load_block;
    logic               mem_excep_flag;

    modport master (
        output exe_to_mem_valid, exe_to_mem_bus, exe_to_mem_excep, exe_to_mem_tlb,
               data_sram_data_ok, data_sram_rdata, wb_allowin, wb_flush,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_signal, mem_to_wb_excep,
               mem_to_wb_tlb, mem_rf_zip, mem_load_block, mem_excep_flag
    );

    modport slave (
        input  exe_to_mem_valid, exe_to_mem_bus, exe_to_mem_excep, exe_to_mem_tlb,
               data_sram_data_ok, data_sram_rdata, wb_allowin, wb_flush,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_signal, mem_to_wb_excep,
               mem_to_wb_tlb, mem_rf_zip, mem_load_block, mem_excep_flag
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Holds one instruction, waits for its data-SRAM
// response, extracts/extends load data, and hands the result to WB.
// Responses belonging to flushed requests are counted and discarded.
// Optional macro MEM_STAGE_FWD_EN: enables MEM->ID forwarding on mem_rf_zip;
// without it mem_rf_zip is 0 and ID is stalled on any MEM writer.
module mem_stage #(
    parameter int EXCEP_W = 128,
    parameter int TLB_W   = 10
) (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  io
);
    logic               mem_valid;
    logic               wait_flag;
    logic [1:0]         discard_cnt;
    logic               buf_valid;
    logic [31:0]        rdata_buf;
    // Latched EXE bus without mem_req_issued (bit 74), which only feeds wait_flag at capture.
    logic [75:0]        bus_r;
    logic [EXCEP_W-1:0] excep_r;
    logic [TLB_W-1:0]   tlb_r;

    logic        inst_cacop;
    logic        excep_any;
    logic [2:0]  load_op;
    logic        res_from_mem;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;

    logic        data_ok_acc;
    logic        mem_readygo;
    logic        mem_leave;
    logic [31:0] load_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign {inst_cacop, excep_any, load_op, res_from_mem, pc, rf_we, rf_waddr, alu_result} = bus_r;

    // Handshake: a response is accepted only when no stale response is pending.
    always_comb begin
        data_ok_acc    = io.data_sram_data_ok & (discard_cnt == 2'd0) & wait_flag;
        mem_readygo    = ~wait_flag | data_ok_acc;
        io.mem_allowin = ~mem_valid | (mem_readygo & io.wb_allowin);
        mem_leave      = mem_valid & mem_readygo & io.wb_allowin;
    end

    // Stage occupancy and outstanding-request flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
            wait_flag <= 1'b0;
        end else if (io.wb_flush) begin
            mem_valid <= 1'b0;
            wait_flag <= 1'b0;
        end else if (io.mem_allowin) begin
            mem_valid <= io.exe_to_mem_valid;
            wait_flag <= io.exe_to_mem_valid & io.exe_to_mem_bus[74];
        end else if (data_ok_acc) begin
            wait_flag <= 1'b0;
        end
    end

    // Bundle latches, loaded whenever EXE hands over an instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_r   <= '0;
            excep_r <= '0;
            tlb_r   <= '0;
        end else if (io.exe_to_mem_valid & io.mem_allowin) begin
            bus_r   <= {io.exe_to_mem_bus[76:75], io.exe_to_mem_bus[73:0]};
            excep_r <= io.exe_to_mem_excep;
            tlb_r   <= io.exe_to_mem_tlb;
        end
    end

    // Count responses still owed to flushed requests; each later data_ok consumes one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt <= 2'd0;
        end else if (io.wb_flush & wait_flag & ~io.data_sram_data_ok) begin
            if (discard_cnt != 2'd3) begin
                discard_cnt <= discard_cnt + 2'd1;
            end
        end else if (io.data_sram_data_ok & (discard_cnt != 2'd0)) begin
            discard_cnt <= discard_cnt - 2'd1;
        end
    end

    // Hold read data that arrived while WB was stalled until the instruction leaves.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_buf <= '0;
            buf_valid <= 1'b0;
        end else begin
            if (data_ok_acc & ~io.wb_allowin) begin
                rdata_buf <= io.data_sram_rdata;
            end
            if (io.wb_flush | mem_leave) begin
                buf_valid <= 1'b0;
            end else if (data_ok_acc & ~io.wb_allowin) begin
                buf_valid <= 1'b1;
            end
        end
    end

    // Load data extraction by byte offset and load type.
    always_comb begin
        load_word = buf_valid ? rdata_buf : io.data_sram_rdata;
        case (alu_result[1:0])
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        load_half = alu_result[1] ? load_word[31:16] : load_word[15:0];
        case (load_op)
            3'b001:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b010:  load_data = {24'd0, load_byte};
            3'b011:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {16'd0, load_half};
            default: load_data = load_word;
        endcase
        final_result = res_from_mem ? load_data : alu_result;
    end

    // Outputs toward WB, EXE and ID.
    always_comb begin
        io.mem_to_wb_valid  = mem_valid & mem_readygo & ~io.wb_flush;
        io.mem_to_wb_signal = {inst_cacop, pc, rf_we, rf_waddr, final_result};
        io.mem_to_wb_excep  = excep_r;
        io.mem_to_wb_tlb    = tlb_r;
        io.mem_excep_flag   = mem_valid & excep_any;
`ifdef MEM_STAGE_FWD_EN
        io.mem_rf_zip       = {mem_valid & rf_we, rf_waddr, final_result};
        io.mem_load_block   = mem_valid & res_from_mem & ~mem_readygo;
`else
        io.mem_rf_zip       = '0;
        io.mem_load_block   = mem_valid & rf_we;
`endif
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Expected WB records are queued at
// capture time by a transaction-level model; a monitor pops them on each WB transfer.
module tb_mem_stage;
    localparam int EXCEP_W = 128;
    localparam int TLB_W   = 10;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if #(.EXCEP_W(EXCEP_W), .TLB_W(TLB_W)) bus ();

    mem_stage #(.EXCEP_W(EXCEP_W), .TLB_W(TLB_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .io     (bus)
    );

    typedef struct {
        logic               cacop;
        logic               excep;
        logic               req;
        logic [2:0]         op;
        logic               rfm;
        logic [31:0]        pc;
        logic               we;
        logic [4:0]         wa;
        logic [31:0]        alu;
        logic [31:0]        rdata;
        logic [EXCEP_W-1:0] exc;
        logic [TLB_W-1:0]   tlb;
    } instr_t;

    typedef struct {
        logic [70:0]        sig;
        logic [EXCEP_W-1:0] exc;
        logic [TLB_W-1:0]   tlb;
    } wb_t;

    wb_t    sb[$];
    wb_t    mon_e;
    int     vectors = 0;
    int     miscompares = 0;

    // transaction-level model of the stage
    bit     occ = 0;
    bit     occ_wait = 0;
    instr_t occ_i;
    int     occ_delay = 0;
    int     disc = 0;
    bit     cap_done = 0;
    instr_t cur;

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned word, b, h;
        word = w;
        b = (word >> (8 * off)) % 256;
        h = (off >= 2) ? (word >> 16) : (word % 65536);
        case (op)
            3'd1:    return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return word;
        endcase
    endfunction

    function automatic wb_t expect_of(input instr_t i);
        wb_t e;
        logic [31:0] fr;
        fr = i.rfm ? ref_load(i.op, i.alu[1:0], i.rdata) : i.alu;
        e.sig = {i.cacop, i.pc, i.we, i.wa, fr};
        e.exc = i.exc;
        e.tlb = i.tlb;
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        int kind;
        kind    = $urandom_range(0, 2);          // 0 alu, 1 load, 2 store
        i.req   = (kind != 0);
        i.rfm   = (kind == 1);
        i.we    = (kind == 1) ? 1'b1 : ((kind == 0) ? 1'($urandom % 2) : 1'b0);
        i.op    = 3'($urandom_range(0, 7));
        i.excep = ($urandom % 8) == 0;
        i.cacop = ($urandom % 16) == 0;
        i.pc    = $urandom;
        i.wa    = 5'($urandom);
        i.alu   = $urandom;
        i.rdata = $urandom;
        i.exc   = {$urandom, $urandom, $urandom, $urandom};
        i.tlb   = 10'($urandom);
        return i;
    endfunction

    function automatic instr_t mk(input logic req, input logic rfm, input logic [2:0] op,
                                  input logic [31:0] alu, input logic [31:0] rdata);
        instr_t i;
        i = rand_instr();
        i.req = req; i.rfm = rfm; i.op = op; i.alu = alu; i.rdata = rdata;
        i.we = 1'b1; i.excep = 1'b0;
        return i;
    endfunction

    task automatic drive_instr(input instr_t i);
        cur = i;
        bus.exe_to_mem_bus   = {i.cacop, i.excep, i.req, i.op, i.rfm, i.pc, i.we, i.wa, i.alu};
        bus.exe_to_mem_excep = i.exc;
        bus.exe_to_mem_tlb   = i.tlb;
    endtask

    task automatic model_reset();
        occ = 0; occ_wait = 0; disc = 0;
        sb.delete();
    endtask

    // One clock cycle: check outputs against the model before the edge, then advance the model.
    task automatic step();
        bit acc, rg, exp_allow, exp_v, exp_lb, exp_ef;
        cap_done = 0;
        @(negedge clk);
        if (!resetn) begin
            check("rst_allowin", bus.mem_allowin, 1);
            check("rst_valid", bus.mem_to_wb_valid, 0);
            check("rst_signal", bus.mem_to_wb_signal, 0);
            check("rst_excep", bus.mem_to_wb_excep, 0);
            check("rst_tlb", bus.mem_to_wb_tlb, 0);
            check("rst_zip", bus.mem_rf_zip, 0);
            check("rst_load_block", bus.mem_load_block, 0);
            check("rst_excep_flag", bus.mem_excep_flag, 0);
        end else begin
            acc       = bus.data_sram_data_ok && disc == 0 && occ && occ_wait;
            rg        = !(occ && occ_wait) || acc;
            exp_allow = !occ || (rg && bus.wb_allowin);
            exp_v     = occ && rg && !bus.wb_flush;
            exp_ef    = occ && occ_i.excep;
`ifdef MEM_STAGE_FWD_EN
            exp_lb    = occ && occ_i.rfm && !rg;
            check("fwd_we", bus.mem_rf_zip[37], occ && occ_i.we);
            if (occ && rg)
                check("fwd_data", bus.mem_rf_zip[36:0], {occ_i.wa, expect_of(occ_i).sig[31:0]});
`else
            exp_lb    = occ && occ_i.we;
            check("zip_zero", bus.mem_rf_zip, 0);
`endif
            check("mem_allowin", bus.mem_allowin, exp_allow);
            check("mem_to_wb_valid", bus.mem_to_wb_valid, exp_v);
            check("mem_load_block", bus.mem_load_block, exp_lb);
            check("mem_excep_flag", bus.mem_excep_flag, exp_ef);

            if (bus.wb_flush && occ && occ_wait && !bus.data_sram_data_ok) begin
                if (disc < 3) disc++;
            end else if (bus.data_sram_data_ok && disc != 0) begin
                disc--;
            end
            if (bus.wb_flush) begin
                if (occ) void'(sb.pop_back());
                occ = 0;
            end else begin
                if (acc) occ_wait = 0;
                if (occ && occ_wait && occ_delay > 0) occ_delay--;
                if (occ && rg && bus.wb_allowin) occ = 0;
                if (bus.exe_to_mem_valid && exp_allow) begin
                    occ = 1; occ_wait = cur.req; occ_i = cur;
                    occ_delay = $urandom_range(0, 3);
                    sb.push_back(expect_of(cur));
                    cap_done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input instr_t i);
        drive_instr(i);
        bus.exe_to_mem_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (cap_done) break;
        end
        if (!cap_done) check("issue_timeout", 0, 1);
        bus.exe_to_mem_valid = 1'b0;
    endtask

    // Scoreboard monitor: every WB transfer must match the oldest queued record.
    always @(negedge clk) begin
        if (resetn && bus.mem_to_wb_valid && bus.wb_allowin) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_signal", bus.mem_to_wb_signal, mon_e.sig);
                check("wb_excep", bus.mem_to_wb_excep, mon_e.exc);
                check("wb_tlb", bus.mem_to_wb_tlb, mon_e.tlb);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.exe_to_mem_valid = 0; bus.exe_to_mem_bus = '0;
        bus.exe_to_mem_excep = '0; bus.exe_to_mem_tlb = '0;
        bus.data_sram_data_ok = 0; bus.data_sram_rdata = '0;
        bus.wb_allowin = 1; bus.wb_flush = 0;
        model_reset();
        step(); step();
        resetn = 1'b1;

        // ALU instruction, one-cycle latency
        issue(mk(0, 0, 3'd0, 32'h1234_5678, 32'h0));
        step(); step();

        // ld.b at offset 3, response two cycles late
        issue(mk(1, 1, 3'd1, 32'h0000_1003, 32'h80AA_BBCC));
        bus.data_sram_rdata = 32'h5555_5555;
        step(); step();
        bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h80AA_BBCC;
        step();
        bus.data_sram_data_ok = 0;
        step();

        // ld.hu at offset 2
        issue(mk(1, 1, 3'd4, 32'h0000_2002, 32'h8001_0000));
        bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h8001_0000;
        step();
        bus.data_sram_data_ok = 0;
        step();

        // flush while waiting; stale response discarded, new load takes the second one
        issue(mk(1, 1, 3'd0, 32'h0000_3000, 32'h1111_2222));
        step();
        bus.wb_flush = 1;
        step();
        bus.wb_flush = 0;
        issue(mk(1, 1, 3'd0, 32'h0000_4000, 32'hCAFE_F00D));
        bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hDEAD_0001;
        step();
        bus.data_sram_rdata = 32'hCAFE_F00D;
        step();
        bus.data_sram_data_ok = 0;
        step();

        // response while WB stalled for 3 cycles; bus data changes afterwards
        issue(mk(1, 1, 3'd0, 32'h0000_5000, 32'h1357_9BDF));
        bus.wb_allowin = 0;
        bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h1357_9BDF;
        step();
        bus.data_sram_data_ok = 0; bus.data_sram_rdata = 32'hA5A5_A5A5;
        step(); step();
        bus.wb_allowin = 1;
        step(); step();

        // reset mid-wait; later response must not be accepted
        issue(mk(1, 1, 3'd0, 32'h0000_6000, 32'h7777_8888));
        step();
        resetn = 1'b0;
        model_reset();
        drive_instr(rand_instr());
        bus.exe_to_mem_valid = 1; bus.data_sram_data_ok = 1;
        step(); step();
        resetn = 1'b1;
        bus.exe_to_mem_valid = 0;
        step();
        bus.data_sram_data_ok = 0;
        step();

        // randomized traffic with an in-order memory responder
        cap_done = 1;
        for (int n = 0; n < 1500; n++) begin
            if (!bus.exe_to_mem_valid || cap_done) begin
                bus.exe_to_mem_valid = ($urandom % 10) < 7;
                if (bus.exe_to_mem_valid) drive_instr(rand_instr());
            end
            bus.wb_allowin = ($urandom % 4) != 0;
            bus.wb_flush = ($urandom % 50) == 0;
            bus.data_sram_data_ok = 0;
            bus.data_sram_rdata = $urandom;
            if (disc > 0) begin
                bus.data_sram_data_ok = 1'($urandom % 2);
            end else if (occ && occ_wait && occ_delay == 0) begin
                bus.data_sram_data_ok = 1;
                bus.data_sram_rdata = occ_i.rdata;
            end
            step();
        end

        // drain
        bus.exe_to_mem_valid = 0; bus.wb_flush = 0; bus.wb_allowin = 1;
        for (int n = 0; n < 30; n++) begin
            bus.data_sram_data_ok = 0;
            bus.data_sram_rdata = $urandom;
            if (disc > 0 || (occ && occ_wait && occ_delay == 0)) begin
                bus.data_sram_data_ok = 1;
                if (disc == 0) bus.data_sram_rdata = occ_i.rdata;
            end
            step();
        end
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter EXCEP_W, default 128, width of the opaque exception/CSR bundle passed through to WB.
REQ-002 SHALL have parameter TLB_W, default 10, width of the opaque TLB bundle passed through to WB.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- resetn  in  1  async active-low reset
- exe_to_mem_valid  in  1  EXE holds a valid instruction
- mem_allowin  out  1  MEM can accept from EXE this cycle
- exe_to_mem_bus  in  77  {inst_cacop, excep_any, mem_req_issued, load_op[2:0], res_from_mem, pc[31:0], rf_we, rf_waddr[4:0], alu_result[31:0]}
- exe_to_mem_excep  in  EXCEP_W  exception/CSR bundle, latched with exe_to_mem_bus
- exe_to_mem_tlb  in  TLB_W  TLB bundle, latched with exe_to_mem_bus
- data_sram_data_ok  in  1  load/store response strobe
- data_sram_rdata  in  32  load response data
- wb_allowin  in  1  WB can accept
- wb_flush  in  1  WB exception/ertn/refetch flush
- mem_to_wb_valid  out  1  valid toward WB
- mem_to_wb_signal  out  71  {inst_cacop, pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}
- mem_to_wb_excep  out  EXCEP_W  latched exception bundle
- mem_to_wb_tlb  out  TLB_W  latched TLB bundle
- mem_rf_zip  out  38  {fwd_we, rf_waddr[4:0], fwd_data[31:0]} forwarding to ID
- mem_load_block  out  1  MEM holds a load whose data has not returned
- mem_excep_flag  out  1  MEM holds an instruction with excep_any=1, used by EXE to suppress stores

Function
REQ-005 SHALL latch all three input bundles and set mem_valid when exe_to_mem_valid and mem_allowin are both 1; when mem_allowin=1 and exe_to_mem_valid=0, mem_valid SHALL clear.
REQ-006 SHALL keep an internal wait flag, set on capture when mem_req_issued=1 and cleared on an accepted data_sram_data_ok.
REQ-007 SHALL compute mem_readygo as: wait flag clear, or data_ok accepted this cycle.
- An instruction with mem_req_issued=0 SHALL be ready in the capture+1 cycle, giving 1-cycle latency.
REQ-008 SHALL compute mem_allowin = !mem_valid | (mem_readygo & wb_allowin).
REQ-009 SHALL drive mem_to_wb_valid = mem_valid & mem_readygo & !wb_flush.
REQ-010 SHALL capture data_sram_rdata into a 32-bit buffer when data_ok is accepted while wb_allowin=0.
- The buffered value SHALL be used until the instruction leaves MEM.
REQ-011 SHALL produce load data from byte offset alu_result[1:0] according to load_op:
- 000 ld.w: full word.
- 001 ld.b: sign-extended byte.
- 010 ld.bu: zero-extended byte.
- 011 ld.h: sign-extended halfword at offset[1].
- 100 ld.hu: zero-extended halfword at offset[1].
- Other encodings SHALL behave as ld.w.
REQ-012 SHALL set final_result to the load data when res_from_mem=1, otherwise to alu_result.
REQ-013 SHALL, on wb_flush, clear mem_valid and the wait flag on the next edge, regardless of EXE valid.
REQ-014 SHALL, when wb_flush arrives while the wait flag is set and no data_ok occurs that cycle, increment a 2-bit discard counter, saturating at 3.
REQ-015 SHALL, whenever data_ok arrives while the discard counter is nonzero, decrement the counter and ignore the data_ok (no readygo, no buffer write).
- Discard SHALL take priority over accepting data_ok for a newly captured instruction.
REQ-016 SHALL drive mem_load_block = mem_valid & res_from_mem & !mem_readygo.
REQ-017 SHALL drive mem_excep_flag = mem_valid & excep_any.
REQ-018 SHALL pass mem_to_wb_excep and mem_to_wb_tlb straight from their latches, unmodified.

Reset
REQ-019 SHALL, when resetn=0, asynchronously clear mem_valid, the wait flag, the discard counter, all latched bundles and the rdata buffer to 0.
- As a result, all outputs SHALL be 0 except mem_allowin, which SHALL be 1.
REQ-020 SHALL ignore data_ok and exe_to_mem_valid during reset.
REQ-021 SHALL resume with an empty stage on the first edge after release.

Configuration
REQ-022 SHALL compile in forwarding when macro MEM_STAGE_FWD_EN is defined: fwd_we = mem_valid & rf_we, and fwd_data = final_result.
REQ-023 SHALL, without MEM_STAGE_FWD_EN, tie mem_rf_zip to 0 and drive mem_load_block = mem_valid & rf_we, so that ID stalls on any MEM writer.

Verification
REQ-024 SHALL cover: ALU instruction (mem_req_issued=0, alu_result=0x1234_5678) -> mem_to_wb_valid one cycle after capture, final_result=0x1234_5678.
REQ-025 SHALL cover: ld.b at offset 3, rdata=0x80AA_BBCC, data_ok 2 cycles late -> mem_load_block=1 for 2 cycles, then final_result=0xFFFF_FF80.
REQ-026 SHALL cover: ld.hu at offset 2, rdata=0x8001_0000 -> final_result=0x0000_8001.
REQ-027 SHALL cover: wb_flush while a load waits, then a new load captured, then two data_ok pulses -> the first data_ok is discarded, and the new load completes with the second pulse's rdata.
REQ-028 SHALL cover: data_ok with wb_allowin=0 for 3 cycles, rdata changed afterwards -> WB receives the originally buffered value.
REQ-029 SHALL cover: resetn asserted mid-wait -> all state cleared, and a later data_ok is not accepted.
